// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM master.
// Contents: command encodings, FSM state enum, frame/data/counter widths
// and a helper that builds the 10-bit outgoing frame from a request.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        SHIFT,
        WAIT,
        READ,
        GAP
    } state_e;

    // Read-data frames carry no payload; the data field is sent as zeros.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]        cmd,
                                                        input logic [DATA_W-1:0] data);
        if (cmd == CMD_RD_DATA) begin
            build_frame = {cmd, {DATA_W{1'b0}}};
        end else begin
            build_frame = {cmd, data};
        end
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Serial datapath for the SPI RAM master.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (counter only)
//   load, frame        parallel load of the 10-bit outgoing frame
//   shift              advance the outgoing frame by one bit (MSB first)
//   sample, miso       shift one MISO bit into the receive register
//   cnt_load, cnt_init load the shared 4-bit down-counter
//   cnt_dec            decrement the down-counter
//   mosi_bit           current outgoing bit (frame MSB)
//   rx_byte            receive shift register contents
//   cnt_zero           down-counter has reached zero
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               shift,
    input  logic               sample,
    input  logic               miso,
    input  logic               cnt_load,
    input  logic [CNT_W-1:0]   cnt_init,
    input  logic               cnt_dec,
    output logic               mosi_bit,
    output logic [DATA_W-1:0]  rx_byte,
    output logic               cnt_zero
);

    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;
    logic [CNT_W-1:0]   cnt_q;

    // Shift registers hold pure data; the FSM gates their visibility.
    always_ff @(posedge clk) begin
        if (load) begin
            tx_q <= frame;
        end else if (shift) begin
            tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (sample) begin
            rx_q <= {rx_q[DATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_load) begin
            cnt_q <= cnt_init;
        end else if (cnt_dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign mosi_bit = tx_q[FRAME_W-1];
    assign rx_byte  = rx_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ram.sv
// SPI master for a serial RAM: accepts one command per handshake and
// sends it as a CMD bit plus a 10-bit {cmd, data} frame; read-data frames
// add a turnaround and an 8-bit MISO read returned on rsp_valid/rsp_data.
// Parameters: TURNAROUND (1..15), IDLE_GAP (1..15).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_cmd[1:0], req_data[7:0]   command and address/write data
//   ss_n, MOSI, MISO              SPI pins (slave shares clk)
//   rsp_valid, rsp_data[7:0]      one-cycle read response, data held
//   busy                          high from acceptance until ready again
//   err (SPI_MASTER_SEQ_CHK_EN)   pulse on read-data without read-address
// Optional feature macro: SPI_MASTER_SEQ_CHK_EN.
module spi_master_ram
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    output logic              ss_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
`ifdef SPI_MASTER_SEQ_CHK_EN
    ,
    output logic              err
`endif
);

    state_e            state_q, state_d;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] rsp_hold_q;
    logic              accept, load, shift, sample, done;
    logic              cnt_load, cnt_dec, cnt_zero, mosi_bit;
    logic [CNT_W-1:0]  cnt_init;
    logic [DATA_W-1:0] rx_byte;

    spi_master_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .frame    (build_frame(req_cmd, req_data)),
        .shift    (shift),
        .sample   (sample),
        .miso     (MISO),
        .cnt_load (cnt_load),
        .cnt_init (cnt_init),
        .cnt_dec  (cnt_dec),
        .mosi_bit (mosi_bit),
        .rx_byte  (rx_byte),
        .cnt_zero (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= done;
            if (rsp_valid) begin
                rsp_hold_q <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q <= req_cmd;
        end
    end

    // Each timed state loads the counter with (length-1) on entry and
    // leaves when it reaches zero.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        sample   = 1'b0;
        done     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_init = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                cnt_load = 1'b1;
                cnt_init = CNT_W'(FRAME_W - 1);
                state_d  = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (cmd_q == CMD_RD_DATA) begin
                        cnt_init = CNT_W'(TURNAROUND - 1);
                        state_d  = WAIT;
                    end else begin
                        cnt_init = CNT_W'(IDLE_GAP - 1);
                        state_d  = GAP;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_init = CNT_W'(DATA_W - 1);
                    state_d  = READ;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            READ: begin
                sample = 1'b1;
                if (cnt_zero) begin
                    done     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_init = CNT_W'(IDLE_GAP - 1);
                    state_d  = GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked while reset is held even though the state is IDLE.
    assign req_ready = (state_q == IDLE) && rst_n;
    assign busy      = (state_q != IDLE);
    assign ss_n      = (state_q == IDLE) || (state_q == GAP);
    assign MOSI      = ((state_q == CMD) || (state_q == SHIFT)) ? mosi_bit : 1'b0;
    // The receive register is stable during the response cycle, so it is
    // presented directly then and latched for holding afterwards.
    assign rsp_data  = rsp_valid ? rx_byte : rsp_hold_q;

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic rd_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= accept && (req_cmd == CMD_RD_DATA) && !rd_pend_q;
            if (accept && (req_cmd == CMD_RD_ADDR)) begin
                rd_pend_q <= 1'b1;
            end else if (accept && (req_cmd == CMD_RD_DATA)) begin
                rd_pend_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_ram.sv
// Self-checking bench for spi_master_ram: a frame/response scoreboard fed
// at request acceptance and drained by a negedge monitor that also plays
// the SPI slave on MISO. Define SPI_MASTER_SEQ_CHK_EN to cover err.
module tb_spi_master_ram;
    import spi_pkg::*;

    localparam int T = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_cmd = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       ss_n;
    logic       MOSI;
    logic       MISO = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef SPI_MASTER_SEQ_CHK_EN
    logic       err;
`endif

    spi_master_ram #(.TURNAROUND(T), .IDLE_GAP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .ss_n      (ss_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef SPI_MASTER_SEQ_CHK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [63:0] bits;
        logic [7:0]  miso;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] rq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic       pend = 1'b0;
    logic       gap_chk = 1'b0;
    int         b2b_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t make_frame(input logic [1:0] c, input logic [7:0] d,
                                          input logic [7:0] m, input int abort);
        frame_t f;
        f.bits = {53'd0, c[1], c, (c == 2'b11) ? 8'h00 : d};
        f.len  = 11;
        if (c == 2'b11) begin
            f.bits = f.bits << (T + 8);
            f.len  = 19 + T;
        end
        if (abort > 0) begin
            f.bits = f.bits >> (f.len - abort);
            f.len  = abort;
        end
        f.miso = m;
        return f;
    endfunction

    task automatic push_req(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m, input int abort);
        fq.push_back(make_frame(c, d, m, abort));
        if (c == 2'b11 && abort == 0) rq.push_back(m);
    endtask

    function automatic logic exp_err(input logic [1:0] c);
        logic e;
        e = (c == 2'b11) && !pend;
        if (c == 2'b10) pend = 1'b1;
        else if (c == 2'b11) pend = 1'b0;
        return e;
    endfunction

    // Monitor and MISO slave model.
    frame_t      cur;
    int          cur_len = 0;
    logic [63:0] cur_bits = '0;
    int          hi_len = 0;
    logic        prev_rv = 1'b0;
    logic        prev_err = 1'b0;

    always @(negedge clk) begin
        int k;
        if (!ss_n) begin
            if (cur_len == 0 && rst_n) begin
                if (gap_chk) begin
                    if (b2b_cnt > 0) check_eq("b2b_gap", hi_len, G + 1);
                    b2b_cnt++;
                end
                if (fq.size() == 0) check_eq("frame_spurious", ss_n, 1'b1);
                else cur = fq[0];
            end
            cur_len++;
            cur_bits = {cur_bits[62:0], MOSI};
            k = cur_len - 12 - T;
            if (k >= 0 && k < 8) MISO = cur.miso[7 - k];
            else MISO = 1'($urandom);
        end else begin
            if (cur_len > 0) begin
                if (fq.size() > 0) begin
                    cur = fq.pop_front();
                    check_eq("frame_len", cur_len, cur.len);
                    check_eq("frame_mosi", cur_bits, cur.bits);
                end
                cur_len  = 0;
                cur_bits = '0;
                hi_len   = 0;
            end
            hi_len++;
            check_eq("mosi_idle", MOSI, 1'b0);
            MISO = 1'($urandom);
        end
        if (rsp_valid) begin
            check_eq("rsp_width", prev_rv, 1'b0);
            if (rq.size() > 0) check_eq("rsp_data", rsp_data, rq.pop_front());
            else check_eq("rsp_spurious", rsp_valid, 1'b0);
        end
        prev_rv = rsp_valid;
`ifdef SPI_MASTER_SEQ_CHK_EN
        if (err) check_eq("err_width", prev_err, 1'b0);
        prev_err = err;
`endif
    end

    task automatic do_req(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m, input int abort);
        int   n;
        logic e;
        req_valid = 1'b1;
        req_cmd   = c;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", req_ready, 1'b1);
        push_req(c, d, m, abort);
        e = exp_err(c);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_data  = 8'($urandom);
        check_eq("busy_after_accept", busy, 1'b1);
        check_eq("ready_after_accept", req_ready, 1'b0);
`ifdef SPI_MASTER_SEQ_CHK_EN
        check_eq("err", err, e);
`else
        e = 1'b0;
`endif
        if (abort > 0) begin
            repeat (abort) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_eq("abort_ss_n", ss_n, 1'b1);
            check_eq("abort_mosi", MOSI, 1'b0);
            check_eq("abort_busy", busy, 1'b0);
            check_eq("abort_ready", req_ready, 1'b0);
            check_eq("abort_rsp_valid", rsp_valid, 1'b0);
            check_eq("abort_rsp_data", rsp_data, 8'h00);
            pend = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check_eq("ready_after_release", req_ready, 1'b1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((fq.size() != 0 || rq.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", fq.size() + rq.size(), 0);
    endtask

    logic [1:0] bc[3] = '{2'b00, 2'b01, 2'b10};
    logic [7:0] bd[3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int last;
        int n;
        repeat (3) @(negedge clk);
        check_eq("rst_ss_n", ss_n, 1'b1);
        check_eq("rst_mosi", MOSI, 1'b0);
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rsp_data, 8'h00);
`ifdef SPI_MASTER_SEQ_CHK_EN
        check_eq("rst_err", err, 1'b0);
`endif
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_reset", req_ready, 1'b1);

        do_req(2'b11, 8'h55, 8'h5A, 0);
        do_req(2'b00, 8'hA5, 8'h00, 0);
        do_req(2'b10, 8'h3F, 8'h00, 0);
        do_req(2'b11, 8'h00, 8'hC3, 0);
        do_req(2'b01, 8'h96, 8'h00, 0);
        wait_idle();
        check_eq("rsp_hold", rsp_data, 8'hC3);

        for (int i = 0; i < 4; i++) begin
            do_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
        end
        wait_idle();

        gap_chk = 1'b1;
        b2b_cnt = 0;
        last = 0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_cmd  = bc[k];
            req_data = bd[k];
            n = 0;
            while (!req_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_eq("b2b_ready", req_ready, 1'b1);
            if (k > 0) check_eq("b2b_spacing", cyc - last, 11 + G + 1);
            last = cyc;
            push_req(bc[k], bd[k], 8'h00, 0);
            void'(exp_err(bc[k]));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_idle();
        gap_chk = 1'b0;
        check_eq("b2b_frames", b2b_cnt, 3);

        do_req(2'b01, 8'h69, 8'h00, 6);
        do_req(2'b01, 8'h81, 8'h00, 0);
        do_req(2'b11, 8'h00, 8'h3C, 0);
        wait_idle();
        repeat (4) @(negedge clk);
        check_eq("end_idle_ss_n", ss_n, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
